ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_redirect  input  1  pipeline redirect (branch/jump taken) from downstream.
REQ-005 SHALL have port i_redirect_pc  input  CPU_WIDTH(64)  redirect target PC.
REQ-006 SHALL have port o_imem_req  output  1  instruction memory request valid.
REQ-007 SHALL have port o_imem_addr  output  CPU_WIDTH  request address, 8-byte aligned ({pc[63:3],3'b0}).
REQ-008 SHALL have port i_imem_gnt  input  1  memory accepts request this cycle.
REQ-009 SHALL have port i_imem_rvalid  input  1  read data valid, at least 1 cycle after grant.
REQ-010 SHALL have port i_imem_rdata  input  64  read data doubleword.
REQ-011 SHALL have port o_post_valid  output  1  instruction valid to decode stage.
REQ-012 SHALL have port i_post_ready  input  1  decode stage ready.
REQ-013 SHALL have port o_ifu_ins  output  INS_WIDTH(32)  fetched instruction.
REQ-014 SHALL have port o_ifu_pc  output  CPU_WIDTH  PC of o_ifu_ins.

Function
REQ-015 SHALL implement FSM states FETCH, WAIT, HOLD, DROP; exactly one memory request outstanding at most.
REQ-016 FETCH: o_imem_req=1, o_imem_addr from pc; on i_imem_gnt -> WAIT; else stay.
REQ-017 WAIT: on i_imem_rvalid capture ins = pc[2] ? rdata[63:32] : rdata[31:0] into output buffer -> HOLD.
REQ-018 HOLD: o_post_valid=1, outputs stable; on i_post_ready -> pc <= pc+4 (mod 2^64), -> FETCH.
REQ-019 o_post_valid SHALL be 0 in FETCH, WAIT, DROP; handshake = o_post_valid & i_post_ready.
REQ-020 Redirect in FETCH: pc <= i_redirect_pc, stay FETCH; request with old address SHALL NOT be granted-as-old (address updates next cycle; a same-cycle grant goes to DROP).
REQ-021 Redirect in WAIT without rvalid: pc <= i_redirect_pc -> DROP; rvalid same cycle: data discarded -> FETCH.
REQ-022 DROP: o_imem_req=0; on i_imem_rvalid discard data -> FETCH; redirect in DROP updates pc, stays DROP.
REQ-023 Redirect in HOLD: pc <= i_redirect_pc -> FETCH; a same-cycle handshake still completes (squash is downstream's job); pc does NOT add 4.
REQ-024 Redirect SHALL take priority over pc+4 in every state.
REQ-025 i_redirect_pc[1:0] SHALL be ignored (treated as 0).
REQ-026 Throughput: one instruction per 3 cycles minimum (gnt and rvalid 1 cycle apart, ready held high).

Reset
REQ-027 While i_rst=1: state=FETCH, pc=RESET_PC, o_post_valid=0, o_imem_req=0, o_ifu_ins=32'h13, o_ifu_pc=0.
REQ-028 First request SHALL assert the cycle after i_rst deasserts; responses for pre-reset requests are not expected.

Structure
REQ-029 CPU_WIDTH, INS_WIDTH, NOP encoding 32'h13 and the FSM state enum SHALL live in the shared core package.
REQ-030 Output buffer (ins, pc) SHALL use one stl_reg instance; FSM and pc kept in ifu.

Verification
REQ-031 Reset release, gnt=1 immediately, rvalid 1 cycle later, ready=1 -> addr 0x8000_0000, then 0x8000_0000 (pc 0x8000_0004, upper word), then 0x8000_0008.
REQ-032 rdata=64'hAAAA_BBBB_1111_2222 at pc 0x...04 -> o_ifu_ins=32'hAAAA_BBBB; at pc 0x...00 -> 32'h1111_2222.
REQ-033 ready=0 for 5 cycles in HOLD -> o_post_valid, o_ifu_ins, o_ifu_pc stable; no new o_imem_req.
REQ-034 Redirect to 0x8000_0100 in WAIT, rvalid 3 cycles later -> data dropped, o_post_valid stays 0, next addr 0x8000_0100.
REQ-035 Redirect to 0x8000_0200 same cycle as HOLD handshake -> one transfer completes, next addr 0x8000_0200, no 0x...+4 fetch.
REQ-036 Assert i_rst mid-WAIT -> next cycle FETCH, pc=RESET_PC, o_post_valid=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg -- shared core definitions used by the instruction fetch unit.
//   CPU_WIDTH   : address / PC width
//   INS_WIDTH   : instruction width
//   NOP_INS     : encoding presented on the instruction output out of reset
//   ifu_state_t : fetch FSM states
//   fetch_buf_t : contents of the fetch output buffer (instruction + its PC)
//   line_addr   : doubleword-aligned memory address for a PC
//   pick_word   : selects the 32-bit half of a fetched doubleword
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam int CPU_WIDTH = 64;
    localparam int INS_WIDTH = 32;

    localparam logic [INS_WIDTH-1:0] NOP_INS = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } ifu_state_t;

    typedef struct packed {
        logic [INS_WIDTH-1:0] ins;
        logic [CPU_WIDTH-1:0] pc;
    } fetch_buf_t;

    // Memory is addressed in whole doublewords; the low three PC bits only
    // choose which instruction inside the returned line is used.
    function automatic logic [CPU_WIDTH-1:0] line_addr(input logic [CPU_WIDTH-1:0] pc);
        return pc & ~64'h0000_0000_0000_0007;
    endfunction

    function automatic logic [INS_WIDTH-1:0] pick_word(input logic [63:0] line,
                                                        input logic        upper);
        logic [INS_WIDTH-1:0] word;
        if (upper) begin
            word = line[63:32];
        end else begin
            word = line[31:0];
        end
        return word;
    endfunction

endpackage

// File: rtl/ifu_stl_reg.sv
// ---------------------------------------------------------------------------
// ifu_stl_reg -- load-enabled register with synchronous reset value.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, loads RESET_VAL
//   en  : load d into q
//   d   : next value
//   q   : registered value, held while en is low
// ---------------------------------------------------------------------------
module ifu_stl_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: reset wins over load, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit, one outstanding memory request at a time.
//   i_clk, i_rst         : clock and synchronous active-high reset
//   i_redirect(_pc)      : taken branch/jump from downstream, new fetch PC
//   o_imem_req/_addr     : request to instruction memory (doubleword aligned)
//   i_imem_gnt           : request accepted
//   i_imem_rvalid/_rdata : response doubleword
//   o_post_valid         : instruction valid to decode
//   i_post_ready         : decode accepts the instruction
//   o_ifu_ins/_pc        : buffered instruction and its PC
// ---------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic                 o_imem_req,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvalid,
    input  logic [63:0]          i_imem_rdata,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic [INS_WIDTH-1:0] o_ifu_ins,
    output logic [CPU_WIDTH-1:0] o_ifu_pc
);

    localparam fetch_buf_t BUF_RESET = '{ins: NOP_INS, pc: 64'h0000_0000_0000_0000};

    ifu_state_t           state_r;
    ifu_state_t           state_next_s;
    logic [CPU_WIDTH-1:0] pc_r;
    logic [CPU_WIDTH-1:0] pc_next_s;
    logic [CPU_WIDTH-1:0] redirect_target_s;
    logic                 req_s;
    logic                 post_valid_s;
    logic                 capture_s;
    fetch_buf_t           buf_d_s;
    fetch_buf_t           buf_q_s;

    // Instructions are 4-byte aligned, so the two low target bits carry no meaning.
    assign redirect_target_s = i_redirect_pc & ~64'h0000_0000_0000_0003;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC register; its next value is chosen alongside the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Next state and next PC. A redirect always overrides the sequential
    // pc+4 step. A grant or response that belongs to a pre-redirect address
    // is routed to DROP (or straight back to FETCH) so its data never
    // reaches the output buffer.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        case (state_r)
            FETCH: begin
                if (i_redirect) begin
                    pc_next_s    = redirect_target_s;
                    state_next_s = i_imem_gnt ? DROP : FETCH;
                end else if (i_imem_gnt) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = FETCH;
                end
            end
            WAIT: begin
                if (i_redirect) begin
                    pc_next_s    = redirect_target_s;
                    state_next_s = i_imem_rvalid ? FETCH : DROP;
                end else if (i_imem_rvalid) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = WAIT;
                end
            end
            HOLD: begin
                // The handshake itself still completes on a redirect; the
                // redirect only decides where fetching resumes.
                if (i_redirect) begin
                    pc_next_s    = redirect_target_s;
                    state_next_s = FETCH;
                end else if (i_post_ready) begin
                    pc_next_s    = pc_r + 64'd4;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = HOLD;
                end
            end
            DROP: begin
                if (i_redirect) begin
                    pc_next_s = redirect_target_s;
                end else begin
                    pc_next_s = pc_r;
                end
                state_next_s = i_imem_rvalid ? FETCH : DROP;
            end
            default: begin
                state_next_s = FETCH;
                pc_next_s    = pc_r;
            end
        endcase
    end

    // FSM outputs. Request and valid are masked by reset so neither is seen
    // while the unit is held in reset.
    always_comb begin
        req_s        = 1'b0;
        post_valid_s = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            FETCH: req_s        = ~i_rst;
            WAIT:  capture_s    = i_imem_rvalid & ~i_redirect;
            HOLD:  post_valid_s = ~i_rst;
            DROP:  req_s        = 1'b0;
            default: begin
                req_s        = 1'b0;
                post_valid_s = 1'b0;
                capture_s    = 1'b0;
            end
        endcase
    end

    assign buf_d_s = '{ins: pick_word(i_imem_rdata, pc_r[2]), pc: pc_r};

    ifu_stl_reg #(
        .WIDTH     ($bits(fetch_buf_t)),
        .RESET_VAL (BUF_RESET)
    ) u_stl_reg (
        .clk (i_clk),
        .rst (i_rst),
        .en  (capture_s),
        .d   (buf_d_s),
        .q   (buf_q_s)
    );

    assign o_imem_req   = req_s;
    assign o_imem_addr  = line_addr(pc_r);
    assign o_post_valid = post_valid_s;
    assign o_ifu_ins    = buf_q_s.ins;
    assign o_ifu_pc     = buf_q_s.pc;

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu -- self-checking bench for ifu. The bench plays instruction memory
// and decode; expected addresses/instructions come from a program-counter
// model (pc+4 per accepted instruction, redirect target otherwise) and a
// fixed memory content function.
// ---------------------------------------------------------------------------
module tb_ifu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [63:0] i_imem_rdata;
    logic        o_post_valid;
    logic        i_post_ready;
    logic [31:0] o_ifu_ins;
    logic [63:0] o_ifu_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    ifu dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_post_valid  (o_post_valid),
        .i_post_ready  (i_post_ready),
        .o_ifu_ins     (o_ifu_ins),
        .o_ifu_pc      (o_ifu_pc)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory contents: one fixed line required by the directed test, a
    // deterministic address hash everywhere else.
    function automatic logic [63:0] mem_line(input logic [63:0] a);
        logic [63:0] l;
        if (a == RST_PC) begin
            l = 64'hAAAA_BBBB_1111_2222;
        end else begin
            l = {a[31:0] ^ 32'h5A5A_C3C3, a[63:32] ^ ~a[31:0]};
        end
        return l;
    endfunction

    function automatic logic [63:0] align8(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction

    // One complete fetch seen from memory/decode. Starts at a negedge with
    // the DUT expected in FETCH for pc; ends at the negedge after the
    // handshake (or redirect) in HOLD.
    task automatic do_fetch(input logic [63:0] pc, input int gd, input int rd, input int hd,
                            input bit redir, input logic [63:0] tgt,
                            output logic [63:0] npc, output logic [31:0] got);
        logic [63:0] line;
        logic [31:0] exp_ins;
        chk("fetch_req", 64'(o_imem_req), 64'd1);
        chk("fetch_addr", o_imem_addr, align8(pc));
        chk("fetch_pv", 64'(o_post_valid), 64'd0);
        for (int i = 0; i < gd; i++) begin
            @(negedge i_clk);
            chk("gnt_wait_req", 64'(o_imem_req), 64'd1);
            chk("gnt_wait_addr", o_imem_addr, align8(pc));
        end
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0;
        for (int i = 0; i < rd; i++) begin
            chk("wait_req", 64'(o_imem_req), 64'd0);
            chk("wait_pv", 64'(o_post_valid), 64'd0);
            @(negedge i_clk);
        end
        chk("wait_req", 64'(o_imem_req), 64'd0);
        chk("wait_pv", 64'(o_post_valid), 64'd0);
        line    = mem_line(align8(pc));
        exp_ins = pc[2] ? line[63:32] : line[31:0];
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = line;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = {$urandom, $urandom};
        for (int i = 0; i <= hd; i++) begin
            chk("hold_pv", 64'(o_post_valid), 64'd1);
            chk("hold_ins", 64'(o_ifu_ins), 64'(exp_ins));
            chk("hold_pc", o_ifu_pc, pc);
            chk("hold_req", 64'(o_imem_req), 64'd0);
            if (i < hd) @(negedge i_clk);
        end
        got = o_ifu_ins;
        if (redir) begin
            i_redirect    = 1'b1;
            i_redirect_pc = tgt;
            i_post_ready  = 1'($urandom_range(0, 1));
            npc           = {tgt[63:2], 2'b00};
        end else begin
            i_post_ready = 1'b1;
            npc          = pc + 64'd4;
        end
        @(negedge i_clk);
        i_redirect   = 1'b0;
        i_post_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] pc;
        logic [63:0] npc;
        logic [31:0] got;
        logic [63:0] tgt;
        int          c0;
        int          hs;

        i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 64'd0;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 64'd0; i_post_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge i_clk);
        chk("rst_req", 64'(o_imem_req), 64'd0);
        chk("rst_pv", 64'(o_post_valid), 64'd0);
        chk("rst_ins", 64'(o_ifu_ins), 64'h13);
        chk("rst_pc", o_ifu_pc, 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Back-to-back fetches at full rate, upper/lower word selection.
        c0 = cyc;
        do_fetch(RST_PC, 0, 0, 0, 1'b0, 64'd0, npc, got);
        chk("thruput_cycles", 64'(cyc - c0), 64'd3);
        chk("ins_lower_word", 64'(got), 64'h1111_2222);
        chk("seq_pc1", npc, 64'h8000_0004);
        do_fetch(npc, 0, 0, 0, 1'b0, 64'd0, npc, got);
        chk("ins_upper_word", 64'(got), 64'hAAAA_BBBB);
        chk("seq_addr3", o_imem_addr, 64'h8000_0008);

        // Decode stalls for 5 cycles in HOLD.
        do_fetch(npc, 1, 2, 5, 1'b0, 64'd0, npc, got);

        // Redirect in WAIT (low target bits set), response 3 cycles later.
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0;
        i_redirect = 1'b1; i_redirect_pc = 64'h8000_0101;
        @(negedge i_clk);
        i_redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drop_pv", 64'(o_post_valid), 64'd0);
            chk("drop_req", 64'(o_imem_req), 64'd0);
            @(negedge i_clk);
        end
        i_imem_rvalid = 1'b1; i_imem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        chk("after_drop_pv", 64'(o_post_valid), 64'd0);
        do_fetch(64'h8000_0100, 0, 0, 0, 1'b0, 64'd0, npc, got);

        // Redirect in the same cycle as the HOLD handshake.
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = mem_line(align8(npc));
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        hs = 0;
        i_post_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 64'h8000_0200;
        if (o_post_valid && i_post_ready) hs++;
        @(negedge i_clk);
        i_post_ready = 1'b0; i_redirect = 1'b0;
        chk("redir_hs_count", 64'(hs), 64'd1);
        chk("redir_hs_pv", 64'(o_post_valid), 64'd0);
        do_fetch(64'h8000_0200, 0, 0, 0, 1'b0, 64'd0, npc, got);

        // Redirect in FETCH with a same-cycle grant: old response dropped.
        i_imem_gnt = 1'b1; i_redirect = 1'b1; i_redirect_pc = 64'h0000_1234_0000_0040;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_redirect = 1'b0;
        chk("fgnt_drop_req", 64'(o_imem_req), 64'd0);
        i_imem_rvalid = 1'b1;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        chk("fgnt_drop_pv", 64'(o_post_valid), 64'd0);
        do_fetch(64'h0000_1234_0000_0040, 0, 0, 0, 1'b0, 64'd0, npc, got);

        // Redirect in WAIT with a same-cycle response: straight back to FETCH.
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_redirect = 1'b1; i_redirect_pc = 64'h0000_0000_0000_0308;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0; i_redirect = 1'b0;
        chk("wrv_pv", 64'(o_post_valid), 64'd0);
        do_fetch(64'h0000_0000_0000_0308, 0, 0, 0, 1'b0, 64'd0, npc, got);

        // PC wraps modulo 2^64.
        do_fetch(npc, 0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, npc, got);
        do_fetch(npc, 0, 1, 0, 1'b0, 64'd0, npc, got);
        chk("wrap_pc", npc, 64'd0);
        pc = npc;

        // Random timing with occasional redirects in HOLD.
        for (int n = 0; n < 40; n++) begin
            tgt = {32'($urandom_range(0, 3)), $urandom};
            do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0), tgt, npc, got);
            pc = npc;
        end
        chk("rand_next_addr", o_imem_addr, align8(pc));

        // Reset asserted mid-WAIT.
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_rst = 1'b1;
        @(negedge i_clk);
        chk("midrst_req", 64'(o_imem_req), 64'd0);
        chk("midrst_pv", 64'(o_post_valid), 64'd0);
        chk("midrst_ins", 64'(o_ifu_ins), 64'h13);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("midrst_fetch_req", 64'(o_imem_req), 64'd1);
        chk("midrst_fetch_addr", o_imem_addr, RST_PC);
        do_fetch(RST_PC, 0, 0, 0, 1'b0, 64'd0, npc, got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
